// File: rtl/ascon_perm_sequencer_if.sv
// ascon_perm_sequencer_if: job request and result handshakes between the mode FSM and the permutation sequencer
interface ascon_perm_sequencer_if;
  logic         start_valid;
  logic         start_ready;
  logic [1:0]   nrounds_sel;
  logic [319:0] state_in;
  logic         result_valid;
  logic         result_ready;
  logic [319:0] result_state;
  modport master (
    output start_valid, nrounds_sel, state_in, result_ready,
    input  start_ready, result_valid, result_state
  );
  modport slave (
    input  start_valid, nrounds_sel, state_in, result_ready,
    output start_ready, result_valid, result_state
  );
endinterface

// File: rtl/ascon_perm_sequencer.sv
// ascon_perm_sequencer: loops an external UNROLL-round ASCON datapath through a p12/p8/p6 permutation
module ascon_perm_sequencer #(
  parameter int UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 nRST,
  ascon_perm_sequencer_if.slave bus,
  output logic [319:0]         dp_state_o,
  output logic [3:0]           dp_rc_idx_o,
  input  logic [319:0]         dp_state_i,
  output logic                 busy,
  output logic                 sel_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_sequencer: UNROLL must be 1 or 2");
  end
  state_t       fsm;
  logic [319:0] st;
  logic [3:0]   ridx;
  logic [3:0]   ridx_nxt;
  logic [3:0]   ridx_first;
  assign ridx_nxt    = ridx + 4'(UNROLL);
  // A p^N run starts at round 12-N so every job ends on round 11; reserved 11 runs as p12
  assign ridx_first  = bus.nrounds_sel == 2'b01 ? 4'd4 : bus.nrounds_sel == 2'b10 ? 4'd6 : 4'd0;
  assign dp_state_o  = st;
  assign dp_rc_idx_o = ridx;
  assign bus.result_state = st;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      fsm              <= IDLE;
      st               <= '0;
      ridx             <= '0;
      sel_err          <= 1'b0;
      busy             <= 1'b0;
      bus.start_ready  <= 1'b1;
      bus.result_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (bus.start_valid) begin
          st              <= bus.state_in;
          ridx            <= ridx_first;
          sel_err         <= sel_err | (bus.nrounds_sel == 2'b11);
          busy            <= 1'b1;
          bus.start_ready <= 1'b0;
          fsm             <= RUN;
        end
        RUN: begin
          st   <= dp_state_i;
          ridx <= ridx_nxt;
          if (ridx_nxt == 4'd12) begin
            bus.result_valid <= 1'b1;
            fsm              <= DONE;
          end
        end
        DONE: if (bus.result_ready) begin
          bus.result_valid <= 1'b0;
          bus.start_ready  <= 1'b1;
          busy             <= 1'b0;
          fsm              <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule
